// File: rtl/mult_defs_pkg.sv
// Shared definitions for the shift-add multiplier controller: state codes and default width.
package mult_defs;

    localparam int MULT_N = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/mult_ctrl_if.sv
// Strobe/handshake bundle between the multiplier controller and its datapath.
interface mult_ctrl_if;
    logic start;
    logic m_lsb;
    logic clr;
    logic ldm;
    logic ldp;
    logic shp;
    logic shm;
    logic busy;
    logic done;

    modport master (
        output start, m_lsb,
        input  clr, ldm, ldp, shp, shm, busy, done
    );

    modport slave (
        input  start, m_lsb,
        output clr, ldm, ldp, shp, shm, busy, done
    );
endinterface

// File: rtl/mult_ctrl_bit_cnt.sv
// Saturating bit counter: cleared on clr, advances on inc, flags the last multiplier bit.
module bit_cnt
    import mult_defs::*;
#(
    parameter int N = MULT_N
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] MAXV = CW'(N - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAXV);
endmodule

// File: rtl/mult_ctrl.sv
// Moore controller for the shift-add multiplier; one product takes 2 + 2N + popcount(M) edges
// from the start sample to the end of the done cycle. start is ignored unless idle.
module mult_ctrl
    import mult_defs::*;
#(
    parameter int N = MULT_N
) (
    input  logic        clk,
    input  logic        rst,
    mult_ctrl_if.slave  ctl
);
    state_t state;
    state_t nxt;
    logic   at_max;
    logic   clr_s, ldm_s, ldp_s, shp_s, shm_s, busy_s, done_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Outputs decode from state alone so nothing combinational reaches the strobes from inputs.
    always_comb begin
        nxt    = S_IDLE;
        clr_s  = 1'b0;
        ldm_s  = 1'b0;
        ldp_s  = 1'b0;
        shp_s  = 1'b0;
        shm_s  = 1'b0;
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state)
            S_IDLE: begin
                nxt = ctl.start ? S_INIT : S_IDLE;
            end
            S_INIT: begin
                clr_s  = 1'b1;
                ldm_s  = 1'b1;
                busy_s = 1'b1;
                nxt    = S_TEST;
            end
            S_TEST: begin
                busy_s = 1'b1;
                nxt    = ctl.m_lsb ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                ldp_s  = 1'b1;
                busy_s = 1'b1;
                nxt    = S_SHIFT;
            end
            S_SHIFT: begin
                shp_s  = 1'b1;
                shm_s  = 1'b1;
                busy_s = 1'b1;
                nxt    = at_max ? S_DONE : S_TEST;
            end
            S_DONE: begin
                done_s = 1'b1;
                nxt    = S_IDLE;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    bit_cnt #(.N(N)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == S_INIT),
        .inc    (state == S_SHIFT),
        .at_max (at_max)
    );

    assign ctl.clr  = clr_s;
    assign ctl.ldm  = ldm_s;
    assign ctl.ldp  = ldp_s;
    assign ctl.shp  = shp_s;
    assign ctl.shm  = shm_s;
    assign ctl.busy = busy_s;
    assign ctl.done = done_s;
endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: N=4 and N=8 instances, bench-side multiplier/product datapath, scoreboard.
module tb_mult_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_ctrl_if if4();
    mult_ctrl_if if8();

    mult_ctrl #(.N(4)) u4 (.clk(clk), .rst(rst), .ctl(if4));
    mult_ctrl #(.N(8)) u8 (.clk(clk), .rst(rst), .ctl(if8));

    typedef struct {
        logic [7:0] m;
        logic [7:0] a;
        int         gap;
    } job_t;

    job_t q0[$];
    job_t q1[$];

    int checks = 0;
    int errors = 0;

    int         nn[2];
    int         cyc[2], n_ldp[2], n_shp[2], n_shm[2], n_clr[2], n_ldm[2];
    int         busy_err[2], since_done[2], stray[2], done_seen[2];
    logic       active[2];
    logic       carry[2];
    logic [7:0] mreg[2];
    logic [7:0] cur_a[2];
    logic [31:0] preg[2];

    assign if4.m_lsb = mreg[0][0];
    assign if8.m_lsb = mreg[1][0];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int popcount(input logic [7:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic mon_step(input int k, input logic clr, input logic ldm, input logic ldp,
                            input logic shp, input logic shm, input logic busy, input logic done);
        job_t        j;
        int          n;
        int          pop;
        logic [31:0] mask;
        logic [31:0] sum;
        n    = nn[k];
        mask = (32'd1 << n) - 32'd1;
        since_done[k]++;
        if (clr) begin
            if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                stray[k]++;
            end else begin
                j = (k == 0) ? q0[0] : q1[0];
                if (j.gap > 0) check($sformatf("init_gap_n%0d", n), since_done[k], j.gap);
            end
            active[k] = 1'b1;
            cyc[k] = 0; n_ldp[k] = 0; n_shp[k] = 0; n_shm[k] = 0; n_clr[k] = 0; n_ldm[k] = 0;
            busy_err[k] = 0; preg[k] = '0; carry[k] = 1'b0;
        end
        if (active[k]) begin
            cyc[k]++;
            n_clr[k] += int'(clr); n_ldm[k] += int'(ldm); n_ldp[k] += int'(ldp);
            n_shp[k] += int'(shp); n_shm[k] += int'(shm);
            if (busy == done) busy_err[k]++;
        end else if (clr | ldm | ldp | shp | shm | busy | done) begin
            stray[k]++;
        end
        if (done && active[k]) begin
            j = (k == 0) ? q0.pop_front() : q1.pop_front();
            pop = popcount(j.m, n);
            check($sformatf("latency_n%0d_m%0h", n, j.m), cyc[k], 2 + 2 * n + pop);
            check($sformatf("ldp_n%0d_m%0h", n, j.m), n_ldp[k], pop);
            check($sformatf("shp_n%0d", n), n_shp[k], n);
            check($sformatf("shm_n%0d", n), n_shm[k], n);
            check($sformatf("clr_ldm_n%0d", n), n_clr[k] * 10 + n_ldm[k], 11);
            check($sformatf("busy_window_n%0d", n), busy_err[k], 0);
            check($sformatf("product_n%0d_%0h_x_%0h", n, j.a, j.m), preg[k], int'(j.a) * int'(j.m));
            active[k] = 1'b0;
            since_done[k] = 0;
            done_seen[k]++;
        end
        // Bench-side datapath: operand registers and the 2N-bit product register with adder carry.
        if (ldm && active[k]) begin
            j = (k == 0) ? q0[0] : q1[0];
            mreg[k]  = j.m;
            cur_a[k] = j.a;
        end
        if (ldp) begin
            sum      = (preg[k] >> n) + (32'(cur_a[k]) & mask);
            carry[k] = sum[n];
            preg[k]  = ((sum & mask) << n) | (preg[k] & mask);
        end
        if (shp) begin
            preg[k]  = (preg[k] >> 1) | (32'(carry[k]) << (2 * n - 1));
            carry[k] = 1'b0;
        end
        if (shm) mreg[k] = mreg[k] >> 1;
    endtask

    always @(negedge clk) begin
        mon_step(0, if4.clr, if4.ldm, if4.ldp, if4.shp, if4.shm, if4.busy, if4.done);
        mon_step(1, if8.clr, if8.ldm, if8.ldp, if8.shp, if8.shm, if8.busy, if8.done);
    end

    task automatic issue(input int k, input logic [7:0] m, input logic [7:0] a, input int gap);
        job_t j;
        j.m = m; j.a = a; j.gap = gap;
        if (k == 0) q0.push_back(j); else q1.push_back(j);
    endtask

    task automatic set_start(input int k, input logic v);
        if (k == 0) if4.start = v; else if8.start = v;
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk);
        set_start(k, 1'b1);
        @(negedge clk);
        set_start(k, 1'b0);
    endtask

    task automatic wait_dones(input int k, input int target);
        for (int i = 0; i < 600 && done_seen[k] < target; i++) @(negedge clk);
        check($sformatf("done_count_n%0d", nn[k]), done_seen[k], target);
    endtask

    task automatic wait_ldp4(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = if4.ldp;
        end
    endtask

    task automatic run(input int k, input logic [7:0] m, input logic [7:0] a);
        issue(k, m, a, 0);
        pulse_start(k);
        wait_dones(k, done_seen[k] + 1);
    endtask

    logic seen;
    logic [7:0] rm, ra;

    initial begin
        nn[0] = 4; nn[1] = 8;
        for (int k = 0; k < 2; k++) begin
            cyc[k] = 0; n_ldp[k] = 0; n_shp[k] = 0; n_shm[k] = 0; n_clr[k] = 0; n_ldm[k] = 0;
            busy_err[k] = 0; since_done[k] = 100; stray[k] = 0; done_seen[k] = 0;
            active[k] = 1'b0; carry[k] = 1'b0; mreg[k] = '0; cur_a[k] = '0; preg[k] = '0;
        end
        if4.start = 1'b0;
        if8.start = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outs_n4", {if4.clr, if4.ldm, if4.ldp, if4.shp, if4.shm, if4.busy, if4.done}, 0);
        check("reset_outs_n8", {if8.clr, if8.ldm, if8.ldp, if8.shp, if8.shm, if8.busy, if8.done}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_outs_n4", {if4.clr, if4.ldm, if4.ldp, if4.shp, if4.shm, if4.busy, if4.done}, 0);

        run(0, 8'h07, 8'h0B);
        run(0, 8'h00, 8'h09);
        run(0, 8'h0F, 8'h0F);
        for (int i = 0; i < 6; i++) begin
            rm = 8'($urandom_range(0, 15));
            ra = 8'($urandom_range(0, 15));
            run(0, rm, ra);
        end

        // start held high: three back-to-back products
        issue(0, 8'h07, 8'h05, 0);
        issue(0, 8'h0A, 8'h0C, 2);
        issue(0, 8'h07, 8'h03, 2);
        @(negedge clk);
        if4.start = 1'b1;
        wait_dones(0, done_seen[0] + 3);
        if4.start = 1'b0;
        repeat (3) @(negedge clk);

        // start pulses during ADD and during DONE are ignored
        issue(0, 8'h07, 8'h0D, 0);
        pulse_start(0);
        wait_ldp4(seen);
        check("s4_saw_ldp", seen, 1);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        for (int i = 0; i < 60 && !if4.done; i++) @(negedge clk);
        check("s4_saw_done", if4.done, 1);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (6) @(negedge clk);
        check("s4_no_restart_busy", if4.busy, 0);
        check("s4_queue_empty", q0.size(), 0);

        // asynchronous reset in the middle of ADD
        issue(0, 8'h07, 8'h0E, 0);
        pulse_start(0);
        wait_ldp4(seen);
        check("s5_saw_ldp", seen, 1);
        #1 rst = 1'b1;
        #1;
        check("s5_ldp_cleared", if4.ldp, 0);
        check("s5_busy_cleared", if4.busy, 0);
        active[0] = 1'b0;
        void'(q0.pop_front());
        @(negedge clk);
        check("s5_outs_in_reset", {if4.clr, if4.ldm, if4.ldp, if4.shp, if4.shm, if4.busy, if4.done}, 0);
        rst = 1'b0;
        @(negedge clk);
        run(0, 8'h07, 8'h0B);

        run(1, 8'hA5, 8'h3C);
        for (int i = 0; i < 2; i++) begin
            rm = 8'($urandom_range(0, 255));
            ra = 8'($urandom_range(0, 255));
            run(1, rm, ra);
        end

        repeat (4) @(negedge clk);
        check("stray_strobes_n4", stray[0], 0);
        check("stray_strobes_n8", stray[1], 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
